// File: rtl/prf_pkg.sv
// Shared constants and types for the multi-ported physical register file.
package prf_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_PREGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } prf_entry_t;

  // Architectural pregs come out of reset mapped and therefore ready.
  function automatic logic [NUM_PREGS-1:0] resetValidMask();
    logic [NUM_PREGS-1:0] mask;
    mask = '0;
    for (int i = 0; i < ARCH_REGS; i++) mask[i] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prf_read_port.sv
// One issue-stage read port: write-first bypass against this cycle's
// writeback/alloc traffic, then a registered data/ready/valid stage.
module prf_read_port
  import prf_pkg::*;
#(
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic                             RdEn,
  input  logic [PREG_W-1:0]                RdAddr,
  input  logic [NUM_PREGS-1:0][DATA_W-1:0] RegData,
  input  logic [NUM_PREGS-1:0]             RegValid,
  input  logic [NUM_WR-1:0]                WrEn,
  input  logic [NUM_WR*PREG_W-1:0]         WrAddr,
  input  logic [NUM_WR*DATA_W-1:0]         WrData,
  input  logic [NUM_ALLOC-1:0]             AllocEn,
  input  logic [NUM_ALLOC*PREG_W-1:0]      AllocAddr,
  output logic [DATA_W-1:0]                RdData,
  output logic                             RdReady,
  output logic                             RdVld
);

  prf_entry_t sel;

  // Higher write ports override lower ones; an alloc then forces not-ready.
  // Preg 0 is never bypassed so it always reads as zero and ready.
  always_comb begin
    sel.data  = RegData[RdAddr];
    sel.valid = RegValid[RdAddr];
    if (RdAddr != '0) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (WrEn[j] && (WrAddr[j*PREG_W +: PREG_W] == RdAddr)) begin
          sel.data  = WrData[j*DATA_W +: DATA_W];
          sel.valid = 1'b1;
        end
      end
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (AllocEn[k] && (AllocAddr[k*PREG_W +: PREG_W] == RdAddr)) begin
          sel.valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      RdData  <= '0;
      RdReady <= 1'b0;
      RdVld   <= 1'b0;
    end else begin
      RdVld <= RdEn;
      if (RdEn) begin
        RdData  <= sel.data;
        RdReady <= sel.valid;
      end
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// Physical register file: storage, write/alloc priority and conflict
// detection, with one prf_read_port per issue read port.
module prf_multiport
  import prf_pkg::*;
#(
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [NUM_ALLOC-1:0]        AllocEn,
  input  logic [NUM_ALLOC*PREG_W-1:0] AllocAddr,
  input  logic [NUM_WR-1:0]           WrEn,
  input  logic [NUM_WR*PREG_W-1:0]    WrAddr,
  input  logic [NUM_WR*DATA_W-1:0]    WrData,
  input  logic [NUM_RD-1:0]           RdEn,
  input  logic [NUM_RD*PREG_W-1:0]    RdAddr,
  output logic [NUM_RD*DATA_W-1:0]    RdData,
  output logic [NUM_RD-1:0]           RdReady,
  output logic [NUM_RD-1:0]           RdVld,
  output logic [NUM_PREGS-1:0]        ValidVec,
  output logic                        WrConflict
);

  logic [NUM_PREGS-1:0][DATA_W-1:0] regData;
  logic [NUM_PREGS-1:0][DATA_W-1:0] nextData;
  logic [NUM_PREGS-1:0]             regValid;
  logic [NUM_PREGS-1:0]             nextValid;
  logic                             conflictNext;
  logic [PREG_W-1:0]                wa;
  logic [PREG_W-1:0]                aa;

  // Writes set data+valid (last port wins), allocs then clear valid, so a
  // same-cycle write+alloc keeps the new data but leaves the preg not ready.
  always_comb begin
    nextData     = regData;
    nextValid    = regValid;
    conflictNext = 1'b0;
    wa           = '0;
    aa           = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa = WrAddr[j*PREG_W +: PREG_W];
      if (WrEn[j] && (wa != '0)) begin
        nextData[wa]  = WrData[j*DATA_W +: DATA_W];
        nextValid[wa] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_ALLOC; k++) begin
      aa = AllocAddr[k*PREG_W +: PREG_W];
      if (AllocEn[k] && (aa != '0)) nextValid[aa] = 1'b0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (WrEn[j] && WrEn[k] &&
            (WrAddr[j*PREG_W +: PREG_W] == WrAddr[k*PREG_W +: PREG_W]) &&
            (WrAddr[j*PREG_W +: PREG_W] != '0)) begin
          conflictNext = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      regData    <= '0;
      regValid   <= resetValidMask();
      WrConflict <= 1'b0;
    end else begin
      regData    <= nextData;
      regValid   <= nextValid;
      WrConflict <= conflictNext;
    end
  end

  assign ValidVec = regValid;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    prf_read_port #(
      .NUM_WR   (NUM_WR),
      .NUM_ALLOC(NUM_ALLOC)
    ) u_rd (
      .CLK      (CLK),
      .Reset    (Reset),
      .RdEn     (RdEn[r]),
      .RdAddr   (RdAddr[r*PREG_W +: PREG_W]),
      .RegData  (regData),
      .RegValid (regValid),
      .WrEn     (WrEn),
      .WrAddr   (WrAddr),
      .WrData   (WrData),
      .AllocEn  (AllocEn),
      .AllocAddr(AllocAddr),
      .RdData   (RdData[r*DATA_W +: DATA_W]),
      .RdReady  (RdReady[r]),
      .RdVld    (RdVld[r])
    );
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Directed scoreboard bench for prf_multiport: reads push expectations,
// a negedge monitor pops and compares whenever a port presents RdVld.
module tb_prf_multiport;

  localparam int DW = 32;
  localparam int PW = 6;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NA = 2;
  localparam logic [63:0] RESET_VV = 64'h0000_0000_FFFF_FFFF;

  logic            CLK;
  logic            Reset;
  logic [NA-1:0]   AllocEn;
  logic [NA*PW-1:0] AllocAddr;
  logic [NW-1:0]   WrEn;
  logic [NW*PW-1:0] WrAddr;
  logic [NW*DW-1:0] WrData;
  logic [NR-1:0]   RdEn;
  logic [NR*PW-1:0] RdAddr;
  logic [NR*DW-1:0] RdData;
  logic [NR-1:0]   RdReady;
  logic [NR-1:0]   RdVld;
  logic [63:0]     ValidVec;
  logic            WrConflict;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        ready;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checkCount = 0;
  int   passCount  = 0;

  prf_multiport dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .AllocEn   (AllocEn),
    .AllocAddr (AllocAddr),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .RdEn      (RdEn),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .RdReady   (RdReady),
    .RdVld     (RdVld),
    .ValidVec  (ValidVec),
    .WrConflict(WrConflict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic clearInputs();
    AllocEn = '0; AllocAddr = '0;
    WrEn = '0; WrAddr = '0; WrData = '0;
    RdEn = '0; RdAddr = '0;
  endtask

  // Reads must be issued in ascending port order within a cycle.
  task automatic issueRead(input int p, input logic [PW-1:0] a, input logic [31:0] d, input logic r);
    exp_t e;
    RdEn[p] = 1'b1;
    RdAddr[p*PW +: PW] = a;
    e.port = p; e.data = d; e.ready = r;
    expQ.push_back(e);
  endtask

  task automatic issueWrite(input int p, input logic [PW-1:0] a, input logic [31:0] d);
    WrEn[p] = 1'b1;
    WrAddr[p*PW +: PW] = a;
    WrData[p*DW +: DW] = d;
  endtask

  task automatic issueAlloc(input int p, input logic [PW-1:0] a);
    AllocEn[p] = 1'b1;
    AllocAddr[p*PW +: PW] = a;
  endtask

  task automatic applyStimulus();
    @(posedge CLK);
    #1;
    clearInputs();
  endtask

  always @(negedge CLK) begin
    for (int r = 0; r < NR; r++) begin
      if (RdVld[r]) begin
        if (expQ.size() == 0) begin
          checkOutput($sformatf("rdUnexpected%0d", r), 64'd1, 64'd0);
        end else begin
          monE = expQ.pop_front();
          checkOutput($sformatf("rdPort%0d", r),
                      {23'd0, 8'(r), RdReady[r], RdData[r*DW +: DW]},
                      {23'd0, 8'(monE.port), monE.ready, monE.data});
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    clearInputs();
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    checkOutput("rstValidVec", ValidVec, RESET_VV);
    checkOutput("rstRdVld", 64'(RdVld), 64'd0);
    checkOutput("rstRdData", 64'(RdData), 64'd0);
    checkOutput("rstConflict", 64'(WrConflict), 64'd0);

    issueRead(0, 6'd0, 32'h0, 1'b1);
    issueRead(1, 6'd5, 32'h0, 1'b1);
    issueRead(2, 6'd31, 32'h0, 1'b1);
    issueRead(3, 6'd32, 32'h0, 1'b0);
    applyStimulus();

    issueAlloc(0, 6'd40);
    applyStimulus();
    checkOutput("vvAlloc40", ValidVec, 64'h0000_0000_FFFF_FFFF);

    issueWrite(1, 6'd40, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("vvWrite40", ValidVec, 64'h0000_0100_FFFF_FFFF);

    issueRead(0, 6'd40, 32'hDEADBEEF, 1'b1);
    issueAlloc(1, 6'd5);
    issueRead(1, 6'd5, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("vvAlloc5", ValidVec, 64'h0000_0100_FFFF_FFDF);

    issueWrite(0, 6'd33, 32'h1234);
    issueRead(0, 6'd33, 32'h1234, 1'b1);
    applyStimulus();
    checkOutput("vvWrite33", ValidVec, 64'h0000_0102_FFFF_FFDF);

    issueWrite(0, 6'd50, 32'hAAAA);
    issueWrite(1, 6'd50, 32'hBBBB);
    applyStimulus();
    checkOutput("conflictPulse", 64'(WrConflict), 64'd1);
    checkOutput("vvWrite50", ValidVec, 64'h0004_0102_FFFF_FFDF);

    issueRead(2, 6'd50, 32'hBBBB, 1'b1);
    applyStimulus();
    checkOutput("conflictClear", 64'(WrConflict), 64'd0);

    issueWrite(0, 6'd0, 32'hFFFF);
    issueAlloc(0, 6'd0);
    issueRead(0, 6'd0, 32'h0, 1'b1);
    applyStimulus();
    checkOutput("vvPreg0", ValidVec, 64'h0004_0102_FFFF_FFDF);

    issueWrite(1, 6'd45, 32'h55);
    issueAlloc(1, 6'd45);
    issueRead(2, 6'd45, 32'h55, 1'b0);
    issueRead(3, 6'd0, 32'h0, 1'b1);
    applyStimulus();

    issueRead(0, 6'd45, 32'h55, 1'b0);
    applyStimulus();

    issueAlloc(0, 6'd33);
    issueRead(0, 6'd33, 32'h1234, 1'b0);
    applyStimulus();
    checkOutput("vvAlloc33", ValidVec, 64'h0004_0100_FFFF_FFDF);

    applyStimulus();
    checkOutput("holdRdVld", 64'(RdVld[0]), 64'd0);
    checkOutput("holdRdData", 64'(RdData[31:0]), 64'h1234);
    checkOutput("holdRdReady", 64'(RdReady[0]), 64'd0);

    // Reads captured at this edge must be dropped by the following reset.
    RdEn = '1;
    RdAddr = {6'd40, 6'd50, 6'd33, 6'd1};
    @(posedge CLK);
    #1 Reset = 1'b1;
    clearInputs();
    #1;
    checkOutput("midRstRdVld", 64'(RdVld), 64'd0);
    checkOutput("midRstRdData", 64'(RdData), 64'd0);
    checkOutput("midRstRdReady", 64'(RdReady), 64'd0);
    checkOutput("midRstValidVec", ValidVec, RESET_VV);
    checkOutput("midRstConflict", 64'(WrConflict), 64'd0);
    @(posedge CLK);
    #1 Reset = 1'b0;

    issueRead(0, 6'd40, 32'h0, 1'b0);
    issueRead(1, 6'd5, 32'h0, 1'b1);
    issueRead(2, 6'd50, 32'h0, 1'b0);
    issueRead(3, 6'd33, 32'h0, 1'b0);
    applyStimulus();

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge CLK);
    checkOutput("scoreboardDrain", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prf_multiport.md
# prf_multiport

Parametrised multi-ported physical register file for the out-of-order core. It holds NUM_PREGS entries, each a data word plus a Valid (ready) bit. Rename clears Valid on allocation; writeback ports set data and Valid; issue-stage read ports return data and Valid one cycle later, with same-cycle write bypass. It sits between the rename/free-list logic, the issue queue and the writeback buses, and replaces the single-port register file.

## Interface
- DATA_W, 32, data word width
- NUM_PREGS, 64, physical registers (power of two, ≥ ARCH_REGS)
- ARCH_REGS, 32, architectural registers mapped at reset (pregs 0..ARCH_REGS-1)
- NUM_RD, 4, read ports
- NUM_WR, 2, write (writeback) ports
- NUM_ALLOC, 2, allocation (Valid-clear) ports
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- AllocEn  in  NUM_ALLOC  per-port allocate strobe
- AllocAddr  in  NUM_ALLOC×PREG_W  preg whose Valid is cleared
- WrEn  in  NUM_WR  per-port write strobe
- WrAddr  in  NUM_WR×PREG_W  write preg
- WrData  in  NUM_WR×DATA_W  write data
- RdEn  in  NUM_RD  per-port read strobe
- RdAddr  in  NUM_RD×PREG_W  read preg
- RdData  out  NUM_RD×DATA_W  registered read data
- RdReady  out  NUM_RD  registered Valid of the read preg
- RdVld  out  NUM_RD  RdData/RdReady qualify this cycle
- ValidVec  out  NUM_PREGS  registered Valid bits of all pregs (wakeup/scoreboard)
- WrConflict  out  1  pulse: two write ports hit the same preg in one cycle

## Operation
- Reset (async): all Data = 0; Valid[i] = 1 for i < ARCH_REGS, else 0. RdData = 0, RdReady = 0, RdVld = 0, WrConflict = 0, ValidVec = reset pattern.
- Preg 0 is hardwired: Data 0, Valid 1; writes and allocs to preg 0 are ignored; reads return 0/ready.
- Alloc: AllocEn[k] clears Valid[AllocAddr[k]] at the edge; Data unchanged.
- Write: WrEn[j] stores WrData[j] and sets Valid at the edge.
- Priority per preg in one cycle: write beats alloc for Data; alloc beats write for Valid (result Valid = 0). Legal rename never produces this; bench flags it.
- Two write ports to the same preg: highest-index port wins; WrConflict = 1 next cycle.
- Read: RdEn[r] captures the entry at the edge; RdVld[r] = 1 next cycle. With RdEn low, RdVld = 0 and RdData/RdReady hold.
- Bypass (write-first): read and write to the same preg in one cycle return the new data with RdReady = 1, unless an alloc to that preg in the same cycle forces RdReady = 0. A same-cycle alloc with no write returns the old data with RdReady = 0.
- ValidVec reflects the post-edge Valid bits (same bits later reads see).

## Timing
- Read latency 1 cycle: RdEn/RdAddr at edge N, RdData/RdReady/RdVld valid after edge N+1.
- Write/alloc visible to ValidVec and to non-bypassed reads after edge N+1. Bypass gives a same-cycle read the effect of a write at edge N.
- WrConflict: single-cycle pulse after the offending edge.
- No stalls and no backpressure; every port accepts every cycle.
- Reset asserted mid-operation: immediate return to reset state; in-flight reads are dropped (RdVld = 0). The first read is accepted on the first edge after deassertion.

## Structure
- Package prf_pkg: PREG_W = $clog2(NUM_PREGS), typedef prf_entry_t (packed: Valid, Data[DATA_W-1:0]), reset-valid function producing the ARCH_REGS mask.
- Sub-module prf_read_port: bypass compare against all write/alloc ports, entry mux and output registers. Instantiated NUM_RD times.
- Storage and write/alloc priority logic live in the top module.

## Test plan
- Reset, then read pregs 0, 5, 31, 32 -> RdData 0 for all; RdReady 1, 1, 1, 0; ValidVec = 0x00000000FFFFFFFF.
- Alloc preg 40, next cycle write 0xDEADBEEF to 40, then read 40 -> ValidVec[40] goes 0 then 1; read returns 0xDEADBEEF, ready 1.
- Same cycle: write 0x1234 to preg 33 and read preg 33 -> next cycle RdData 0x1234, RdReady 1 (bypass).
- WrEn both ports to preg 50 with 0xAAAA (port 0) and 0xBBBB (port 1) -> stored 0xBBBB; WrConflict pulses once.
- Write 0xFFFF to preg 0 and alloc preg 0, then read preg 0 -> RdData 0, RdReady 1.
- Issue reads on all 4 ports, assert Reset between the edges -> RdVld 0, all outputs at reset values, Valid pattern restored.
